// File: rtl/spine_switch_pkg.sv
// Shared definitions for the spine switch.
// Flit layout: dest address in flit[15:10]; the destination leaf group is dest[5:4].
package spine_switch_pkg;

  localparam int unsigned FLIT_DWIDTH = 16;
  localparam int unsigned NUM_PORTS   = 4;

  // Dest field position inside a flit.
  localparam int unsigned DEST_MSB = 15;
  localparam int unsigned DEST_LSB = 10;
  localparam int unsigned DEST_W   = DEST_MSB - DEST_LSB + 1;

  // Group (output leaf) field position inside the dest field.
  localparam int unsigned GRP_MSB = 5;
  localparam int unsigned GRP_LSB = 4;

  typedef logic [1:0] leaf_idx_t;

endpackage

// File: rtl/spine_fifo.sv
// Synchronous FIFO buffering one leaf input of the spine switch.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_push, i_wdata   write request and data; accepted when not full or popping this cycle
//   i_pop             read request; ignored when empty
//   o_rdata           head entry (valid when !o_empty)
//   o_full, o_empty   registered occupancy flags
//   o_count           registered occupancy
module spine_fifo #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DWIDTH-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop frees the head slot this cycle, so a full FIFO can still take a write.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: it is only read while the count says it holds data.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/spine_switch.sv
// 4-port spine switch: one FIFO per leaf input, per-output round-robin arbiter,
// registered outputs. A flit is routed to the leaf named by dest[5:4] of its
// dest field (flit[15:10]). Inputs have no backpressure; flits arriving at a
// full FIFO that is not popping are dropped and counted.
// Ports:
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   leafK_in_data/_valid          flit from leaf K (K = 0..3)
//   leafK_out_data/_valid         flit to leaf K, valid for one cycle per flit
//   leafK_dest_addr               leafK_out_data[15:10]
//   fifo_full, fifo_empty         per-input buffer state, bit K = leaf K
//   overflow                      sticky per-input drop flag
//   drop_count                    saturating count of dropped flits
module spine_switch
  import spine_switch_pkg::*;
#(
  parameter int unsigned DWIDTH     = FLIT_DWIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SPINE_ID   = 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [DWIDTH-1:0] leaf0_in_data,
  input  logic              leaf0_in_valid,
  input  logic [DWIDTH-1:0] leaf1_in_data,
  input  logic              leaf1_in_valid,
  input  logic [DWIDTH-1:0] leaf2_in_data,
  input  logic              leaf2_in_valid,
  input  logic [DWIDTH-1:0] leaf3_in_data,
  input  logic              leaf3_in_valid,
  output logic [DWIDTH-1:0] leaf0_out_data,
  output logic              leaf0_out_valid,
  output logic [DEST_W-1:0] leaf0_dest_addr,
  output logic [DWIDTH-1:0] leaf1_out_data,
  output logic              leaf1_out_valid,
  output logic [DEST_W-1:0] leaf1_dest_addr,
  output logic [DWIDTH-1:0] leaf2_out_data,
  output logic              leaf2_out_valid,
  output logic [DEST_W-1:0] leaf2_dest_addr,
  output logic [DWIDTH-1:0] leaf3_out_data,
  output logic              leaf3_out_valid,
  output logic [DEST_W-1:0] leaf3_dest_addr,
  output logic [3:0]        fifo_full,
  output logic [3:0]        fifo_empty,
  output logic [3:0]        overflow,
  output logic [7:0]        drop_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // Spine identity carries no routing meaning.
  logic [7:0] w_unused_spine_id;
  assign w_unused_spine_id = 8'(SPINE_ID);

  logic [DWIDTH-1:0]    w_in_data  [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_in_valid;
  logic [DWIDTH-1:0]    w_head     [NUM_PORTS];
  leaf_idx_t            w_head_grp [NUM_PORTS];
  logic [CW-1:0]        w_unused_count [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_empty;
  logic [NUM_PORTS-1:0] w_push;
  logic [NUM_PORTS-1:0] w_pop;
  logic [NUM_PORTS-1:0] w_drop;

  // Indexed [output][input].
  logic [NUM_PORTS-1:0] w_req [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_gnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_gnt_vld;
  leaf_idx_t            w_gnt_idx [NUM_PORTS];
  leaf_idx_t            w_cand;

  logic [2:0] w_drop_num;
  logic [8:0] w_drop_sum;
  logic [7:0] w_drop_next;

  leaf_idx_t            r_rr_ptr   [NUM_PORTS];
  logic [DWIDTH-1:0]    r_out_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_out_valid;
  logic [3:0]           r_overflow;
  logic [7:0]           r_drop_count;

  assign w_in_data[0] = leaf0_in_data;
  assign w_in_data[1] = leaf1_in_data;
  assign w_in_data[2] = leaf2_in_data;
  assign w_in_data[3] = leaf3_in_data;
  assign w_in_valid   = {leaf3_in_valid, leaf2_in_valid, leaf1_in_valid, leaf0_in_valid};

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
    spine_fifo #(
      .DWIDTH (DWIDTH),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .i_clk   (ACLK),
      .i_rst_n (ARESETn),
      .i_push  (w_push[gi]),
      .i_wdata (w_in_data[gi]),
      .i_pop   (w_pop[gi]),
      .o_rdata (w_head[gi]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi]),
      .o_count (w_unused_count[gi])
    );
    assign w_head_grp[gi] = w_head[gi][DEST_LSB+GRP_MSB:DEST_LSB+GRP_LSB];
  end

  // Each non-empty input requests exactly the output its head flit names.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_req[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_req[o][i] = ~w_empty[i] & (w_head_grp[i] == leaf_idx_t'(o));
      end
    end
  end

  // Round-robin: first requester at or after the pointer, wrapping 3 -> 0.
  always_comb begin
    w_cand = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_gnt_vld[o] = 1'b0;
      w_gnt_idx[o] = '0;
      w_gnt[o]     = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        w_cand = r_rr_ptr[o] + leaf_idx_t'(k);
        if (!w_gnt_vld[o] && w_req[o][w_cand]) begin
          w_gnt_vld[o]     = 1'b1;
          w_gnt_idx[o]     = w_cand;
          w_gnt[o][w_cand] = 1'b1;
        end
      end
    end
  end

  // An input requests a single output, so it can be popped at most once.
  always_comb begin
    w_pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_pop = w_pop | w_gnt[o];
    end
    w_push = w_in_valid & (~w_full | w_pop);
    w_drop = w_in_valid & w_full & ~w_pop;
  end

  always_comb begin
    w_drop_num = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_drop_num = w_drop_num + 3'(w_drop[i]);
    end
    w_drop_sum  = {1'b0, r_drop_count} + 9'(w_drop_num);
    w_drop_next = (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_out_valid  <= '0;
      r_overflow   <= '0;
      r_drop_count <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_rr_ptr[o]   <= '0;
        r_out_data[o] <= '0;
      end
    end else begin
      r_out_valid  <= w_gnt_vld;
      r_overflow   <= r_overflow | w_drop;
      r_drop_count <= w_drop_next;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_gnt_vld[o]) begin
          r_out_data[o] <= w_head[w_gnt_idx[o]];
          r_rr_ptr[o]   <= w_gnt_idx[o] + leaf_idx_t'(1);
        end
      end
    end
  end

  assign leaf0_out_data  = r_out_data[0];
  assign leaf1_out_data  = r_out_data[1];
  assign leaf2_out_data  = r_out_data[2];
  assign leaf3_out_data  = r_out_data[3];
  assign leaf0_out_valid = r_out_valid[0];
  assign leaf1_out_valid = r_out_valid[1];
  assign leaf2_out_valid = r_out_valid[2];
  assign leaf3_out_valid = r_out_valid[3];
  assign leaf0_dest_addr = r_out_data[0][DEST_MSB:DEST_LSB];
  assign leaf1_dest_addr = r_out_data[1][DEST_MSB:DEST_LSB];
  assign leaf2_dest_addr = r_out_data[2][DEST_MSB:DEST_LSB];
  assign leaf3_dest_addr = r_out_data[3][DEST_MSB:DEST_LSB];
  assign fifo_full       = w_full;
  assign fifo_empty      = w_empty;
  assign overflow        = r_overflow;
  assign drop_count      = r_drop_count;

endmodule

// File: tb/tb_spine_switch.sv
module tb_spine_switch;

  logic        ACLK;
  logic        ARESETn;
  logic [15:0] id [4];
  logic [3:0]  iv;
  wire  [3:0]  ov;
  wire  [15:0] od [4];
  wire  [5:0]  da [4];
  wire  [3:0]  fifo_full;
  wire  [3:0]  fifo_empty;
  wire  [3:0]  overflow;
  wire  [7:0]  drop_count;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q [4][$];
  logic [3:0]  sb_off;

  spine_switch dut (
    .ACLK            (ACLK),
    .ARESETn         (ARESETn),
    .leaf0_in_data   (id[0]),
    .leaf0_in_valid  (iv[0]),
    .leaf1_in_data   (id[1]),
    .leaf1_in_valid  (iv[1]),
    .leaf2_in_data   (id[2]),
    .leaf2_in_valid  (iv[2]),
    .leaf3_in_data   (id[3]),
    .leaf3_in_valid  (iv[3]),
    .leaf0_out_data  (od[0]),
    .leaf0_out_valid (ov[0]),
    .leaf0_dest_addr (da[0]),
    .leaf1_out_data  (od[1]),
    .leaf1_out_valid (ov[1]),
    .leaf1_dest_addr (da[1]),
    .leaf2_out_data  (od[2]),
    .leaf2_out_valid (ov[2]),
    .leaf2_dest_addr (da[2]),
    .leaf3_out_data  (od[3]),
    .leaf3_out_valid (ov[3]),
    .leaf3_dest_addr (da[3]),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .overflow        (overflow),
    .drop_count      (drop_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one edge, then score every output that fired against its queue.
  task automatic step();
    logic [15:0] e;
    @(posedge ACLK);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (ov[k] === 1'b1 && !sb_off[k]) begin
        if (exp_q[k].size() == 0) begin
          check($sformatf("spurious_out%0d", k), {31'd0, ov[k]}, 32'd0);
        end else begin
          e = exp_q[k].pop_front();
          check($sformatf("out%0d_data", k), {16'd0, od[k]}, {16'd0, e});
          check($sformatf("out%0d_dest", k), {26'd0, da[k]}, {26'd0, e[15:10]});
        end
      end
    end
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
           && n < max_cycles) begin
      step();
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("missing_out%0d", k), exp_q[k].size(), 0);
      exp_q[k].delete();
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    iv      = '0;
    sb_off  = '0;
    for (int k = 0; k < 4; k++) id[k] = '0;

    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_empty", fifo_empty, 4'hF);
    check("rst_full", fifo_full, 4'h0);
    check("rst_overflow", overflow, 4'h0);
    check("rst_drops", drop_count, 8'h00);
    check("rst_valid", ov, 4'h0);
    check("rst_data1", od[1], 16'h0000);
    check("rst_dest1", da[1], 6'h00);
    ARESETn = 1'b1;

    // Single flit leaf0 -> leaf1, two edges to output
    iv[0] = 1'b1;
    id[0] = 16'h4123;
    exp_q[1].push_back(16'h4123);
    step();
    iv = '0;
    check("single_lat1_valid", ov, 4'h0);
    check("single_empty", fifo_empty, 4'b1110);
    step();
    check("single_valid", ov, 4'b0010);
    check("single_seen", exp_q[1].size(), 0);
    check("single_other0", od[0], 16'h0000);
    check("single_other2", od[2], 16'h0000);
    check("single_other3", od[3], 16'h0000);
    step();
    check("single_pulse", ov, 4'h0);

    // Two bursts of all four leaves to leaf3; each served 0,1,2,3
    for (int b = 0; b < 2; b++) begin
      iv = 4'hF;
      for (int s = 0; s < 4; s++) begin
        id[s] = 16'hC000 | 16'(b << 4) | 16'(s);
        exp_q[3].push_back(id[s]);
      end
      step();
      iv = '0;
      check("burst_lat", ov, 4'h0);
      for (int c = 0; c < 4; c++) begin
        step();
        check($sformatf("burst%0d_cyc%0d_valid", b, c), ov, 4'b1000);
      end
      check("burst_done", exp_q[3].size(), 0);
    end

    // Independent outputs in parallel, including a U-turn on leaf3
    iv    = 4'b1011;
    id[0] = 16'h800A;
    id[1] = 16'h0055;
    id[3] = 16'hC0AA;
    exp_q[2].push_back(16'h800A);
    exp_q[0].push_back(16'h0055);
    exp_q[3].push_back(16'hC0AA);
    step();
    iv = '0;
    check("par_lat", ov, 4'h0);
    step();
    check("par_valid", ov, 4'b1101);
    drain(4);

    // Four leaves stream 6 flits each to leaf3: cyclic service, last flit of
    // leaves 1..3 dropped in one cycle; leaf3 full-and-popped at edge 5 accepts
    for (int i = 0; i < 6; i++) begin
      for (int s = 0; s < 4; s++) begin
        if (i < 5 || s == 0) exp_q[3].push_back(16'hC000 | 16'(s << 8) | 16'(i));
      end
    end
    for (int i = 0; i < 6; i++) begin
      iv = 4'hF;
      for (int s = 0; s < 4; s++) id[s] = 16'hC000 | 16'(s << 8) | 16'(i);
      step();
      if (i == 3) check("cont_full_e4", fifo_full, 4'b1000);
      if (i == 4) begin
        check("pushpop_full", fifo_full, 4'hF);
        check("pushpop_nodrop", drop_count, 8'd0);
        check("pushpop_noovf", overflow, 4'h0);
      end
      if (i == 5) begin
        check("cont_drops", drop_count, 8'd3);
        check("cont_overflow", overflow, 4'b1110);
        check("cont_full_e6", fifo_full, 4'hF);
      end
    end
    iv = '0;
    drain(40);
    check("cont_ovf_sticky", overflow, 4'b1110);
    check("cont_empty", fifo_empty, 4'hF);

    // Saturation: heavy contention on leaf0 output for many cycles
    sb_off[0] = 1'b1;
    iv = 4'hF;
    for (int s = 0; s < 4; s++) id[s] = 16'h0000 | 16'(s);
    for (int c = 0; c < 110; c++) step();
    iv = '0;
    check("sat_drops", drop_count, 8'hFF);
    check("sat_overflow", overflow, 4'hF);
    step();
    check("busy_before_rst", ov[0], 1'b1);

    // Mid-operation reset clears everything at once
    #2;
    ARESETn = 1'b0;
    #1;
    check("arst_valid", ov, 4'h0);
    check("arst_data0", od[0], 16'h0000);
    check("arst_dest0", da[0], 6'h00);
    check("arst_empty", fifo_empty, 4'hF);
    check("arst_full", fifo_full, 4'h0);
    check("arst_overflow", overflow, 4'h0);
    check("arst_drops", drop_count, 8'h00);
    for (int c = 0; c < 2; c++) begin
      @(posedge ACLK);
      #1;
      check("in_rst_valid", ov, 4'h0);
    end
    sb_off = '0;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    ARESETn = 1'b1;

    // First edge after release accepts input; nothing stale emerges
    iv[1] = 1'b1;
    id[1] = 16'h8077;
    exp_q[2].push_back(16'h8077);
    step();
    iv = '0;
    check("post_rst_accept", fifo_empty, 4'b1101);
    check("post_rst_lat", ov, 4'h0);
    step();
    check("post_rst_valid", ov, 4'b0100);
    for (int c = 0; c < 4; c++) step();
    drain(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spine_switch.md
SPINE_SWITCH -- requirements
Module: spine_switch

Interface
REQ-001 Parameter DWIDTH, default 16, flit width; dest address is flit[15:10].
REQ-002 Parameter FIFO_DEPTH, default 4, per-input buffer depth in flits (power of two).
REQ-003 Parameter SPINE_ID, default 1, identity of this spine (status only, no routing effect).
REQ-004 ACLK  input  1  single clock; all logic on rising edge.
REQ-005 ARESETn  input  1  asynchronous active-low reset.
REQ-006 leafK_in_data  input  16  flit from leaf router K's spine output (K = 0..3).
REQ-007 leafK_in_valid  input  1  flit qualifier; no ready exists, so the leaf never stalls.
REQ-008 leafK_out_data  output  16  flit to leaf router K's spine input.
REQ-009 leafK_out_valid  output  1  one-cycle qualifier per flit.
REQ-010 leafK_dest_addr  output  6  copy of leafK_out_data[15:10], valid with leafK_out_valid.
REQ-011 fifo_full / fifo_empty  output  4 each  per-input buffer state, bit K = leaf K.
REQ-012 overflow  output  4  sticky per-input drop flag.
REQ-013 drop_count  output  8  saturating total of dropped flits.

Function
REQ-014 Output leaf index SHALL be dest[5:4] of the head flit (4 groups of 16 endpoints); dest[3:0] is not inspected.
REQ-015 Each input SHALL write the flit into its FIFO whenever in_valid=1 and the FIFO is not full, or is full and pops in the same cycle.
REQ-016 in_valid=1 with FIFO full and no same-cycle pop SHALL drop the flit, set overflow[K], and increment drop_count unless it is 255.
REQ-017 Simultaneous drops on several inputs in one cycle SHALL add their count to drop_count, saturating at 255.
REQ-018 Each output SHALL have a 2-bit round-robin pointer; the grant goes to the first requesting input at or after the pointer, wrapping 3->0.
REQ-019 On grant the pointer SHALL move to granted index + 1 mod 4; with no grant it SHALL hold.
REQ-020 An input SHALL request only the output named by its head flit; at most one pop per input per cycle.
REQ-021 A granted head SHALL be popped, and out_data, out_valid=1 and dest_addr SHALL be registered; with no grant, out_valid=0 and data holds its last value.
REQ-022 Latency: a flit written to an empty FIFO at edge N SHALL appear at the output at edge N+1 if uncontended. Minimum 2 cycles from in_valid to out_valid.
REQ-023 U-turn (dest group == source leaf) SHALL be forwarded normally.
REQ-024 Four inputs targeting one output SHALL each be served once in four consecutive cycles; independent outputs SHALL proceed in parallel.
REQ-025 fifo_full/fifo_empty SHALL reflect registered occupancy after the current edge.

Reset
REQ-026 ARESETn low SHALL immediately clear all FIFO pointers and counts, out_valid, out_data, dest_addr, RR pointers, overflow and drop_count to 0; fifo_empty=4'hF, fifo_full=0.
REQ-027 Flits buffered when reset asserts mid-operation SHALL be discarded, and no out_valid SHALL occur during reset.
REQ-028 Inputs SHALL be accepted from the first rising edge after ARESETn deasserts.

Structure
REQ-029 Shared package: DWIDTH, dest field offsets [15:10], group field [5:4], port count 4, and the leaf index type.
REQ-030 One sub-module, spine_fifo (synchronous FIFO with full/empty and count), SHALL be instanced once per input; arbiter and output registers are inline.

Verification
REQ-031 Single flit 16'h4123 (dest 6'h10) on leaf0 -> leaf1_out_valid pulse two cycles later, data 16'h4123, dest_addr 6'h10; all other outputs stay 0.
REQ-032 All four leaves send dest 6'h30 at once -> leaf3 out emits the flits from leaf 0,1,2,3 on four consecutive cycles; the next burst starts from leaf 0 again.
REQ-033 leaf2 streams 6 back-to-back flits to a leaf3 output held busy by contention -> overflow[2]=1 and drop_count matches the rejected flits.
REQ-034 Push and pop on a full FIFO in the same cycle -> the flit is accepted, no drop, and fifo_full stays 1.
REQ-035 ARESETn pulsed low while FIFOs hold data -> outputs go to 0 immediately, fifo_empty=4'hF, and no stale flit is emitted after release.
REQ-036 300 forced drops -> drop_count saturates at 8'hFF.
